alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 77 +++++++
 rtl/alu_sequencer_reg_select_decoder.sv | 15 +
 rtl/alu_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: FSM states, instruction opcodes,
// ALU operation codes and small opcode classification helpers.
package alu_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T1W  = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_T6   = 4'd8
  } state_t;

  localparam logic [4:0] OP_ADD = 5'h03;
  localparam logic [4:0] OP_SUB = 5'h04;
  localparam logic [4:0] OP_SHR = 5'h05;
  localparam logic [4:0] OP_SHL = 5'h06;
  localparam logic [4:0] OP_ROR = 5'h07;
  localparam logic [4:0] OP_ROL = 5'h08;
  localparam logic [4:0] OP_AND = 5'h09;
  localparam logic [4:0] OP_OR  = 5'h0A;
  localparam logic [4:0] OP_MUL = 5'h0B;
  localparam logic [4:0] OP_DIV = 5'h0C;
  localparam logic [4:0] OP_NEG = 5'h0D;
  localparam logic [4:0] OP_NOT = 5'h0E;

  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_AND = 5'd3;
  localparam logic [4:0] ALU_OR  = 5'd4;
  localparam logic [4:0] ALU_SHR = 5'd5;
  localparam logic [4:0] ALU_SHL = 5'd6;
  localparam logic [4:0] ALU_NOP = 5'd7;
  localparam logic [4:0] ALU_ROR = 5'd8;
  localparam logic [4:0] ALU_ROL = 5'd9;
  localparam logic [4:0] ALU_MUL = 5'd10;
  localparam logic [4:0] ALU_DIV = 5'd11;
  localparam logic [4:0] ALU_NEG = 5'd12;
  localparam logic [4:0] ALU_NOT = 5'd13;

  // Memory wait cycles tolerated in T1W before declaring a fault
  localparam logic [7:0] WAIT_LIMIT = 8'd255;

  function automatic logic is_legal(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic [4:0] alu_map(input logic [4:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_SHR:  return ALU_SHR;
      OP_SHL:  return ALU_SHL;
      OP_ROR:  return ALU_ROR;
      OP_ROL:  return ALU_ROL;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      OP_NEG:  return ALU_NEG;
      OP_NOT:  return ALU_NOT;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_reg_select_decoder.sv
// 4-to-16 one-hot register select decoder; all-zero when not enabled.
module reg_select_decoder (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_dec
      assign onehot[gi] = en && (sel == 4'(gi));
    end
  endgenerate

endmodule

// File: rtl/alu_sequencer.sv
// Control sequencer for a bus-based datapath: fetch with memory wait, decode
// and three-operand execute; all strobes decoded from the present state and IR.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic        Clock,
  input  logic        clr,
  input  logic        Run,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        PCin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  ALU_Sel,
  output logic        Done,
  output logic        illegal_op,
  output logic        mem_fault,
  output logic [3:0]  state
);

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic [4:0] opcode;
  logic       rin_en, rout_en;
  logic [3:0] rout_sel;
  logic       unused_ir_bits;

  assign opcode         = IR[31:27];
  assign unused_ir_bits = ^IR[14:0];
  assign state          = state_reg;

  always_ff @(posedge Clock) begin
    if (clr) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; PCin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; HIin = 1'b0; LOin = 1'b0;
    IncPC = 1'b0; Read = 1'b0;
    Done = 1'b0; illegal_op = 1'b0; mem_fault = 1'b0;
    ALU_Sel  = ALU_NOP;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = IR[22:19];
    case (state_reg)
      S_IDLE: if (Run) state_next = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1;
        state_next = S_T1W;
      end
      S_T1W: begin
        Read  = 1'b1;
        MDRin = mem_ready;
        // Data arriving on the last permitted cycle still wins over the fault
        if (mem_ready) begin
          state_next = S_T2;
        end else if (wait_cnt_reg == WAIT_LIMIT - 8'd1) begin
          mem_fault  = 1'b1;
          state_next = S_IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        if (!is_legal(opcode)) begin
          illegal_op = 1'b1;
          state_next = S_IDLE;
        end else begin
          rout_en = 1'b1; Yin = 1'b1;
          state_next = S_T4;
        end
      end
      S_T4: begin
        rout_en  = !is_unary(opcode);
        rout_sel = IR[18:15];
        ALU_Sel  = alu_map(opcode);
        Zin      = 1'b1;
        state_next = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv(opcode)) begin
          LOin = 1'b1;
          state_next = S_T6;
        end else begin
          rin_en = 1'b1; Done = 1'b1;
          state_next = Run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1; Done = 1'b1;
        state_next = Run ? S_T0 : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  reg_select_decoder u_rin_dec (
    .en     (rin_en),
    .sel    (IR[26:23]),
    .onehot (Rin)
  );

  reg_select_decoder u_rout_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (Rout)
  );

endmodule
